// File: rtl/fsm_chain_if.sv
// fsm_chain_if: symbol stream bundle for the fsm_chain delay line.
//   data_in   : N-bit symbol into stage 1, sampled every clock
//   data_out  : N-bit binary-decoded state of the last stage
//   err_state : sticky flag, set once any stage has held a non-one-hot state
// Modports: master drives symbols and observes outputs; slave is the chain itself.
interface fsm_chain_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0] data_in;
  logic [N-1:0] data_out;
  logic         err_state;

  modport master (
    output data_in,
    input  data_out,
    input  err_state
  );

  modport slave (
    input  data_in,
    output data_out,
    output err_state
  );
endinterface

// File: rtl/fsm_chain.sv
// fsm_chain: K cascaded Moore stages, each holding one N-bit symbol as a one-hot
// state of 2^N bits. The chain is a pure K-clock delay line; any stage found in a
// non-one-hot state is forced back to S0, passes symbol 0 downstream, and sets a
// sticky error flag so upset experiments can observe the corruption.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-low reset (all stages to S0, flag cleared)
//   bus   : fsm_chain_if.slave (data_in, data_out, err_state)
module fsm_chain #(
  parameter int unsigned N = 4,
  parameter int unsigned K = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  fsm_chain_if.slave  bus
);

  localparam int unsigned S = 1 << N;

  logic [K-1:0][S-1:0] st_q, st_d;
  logic [K-1:0]        legal;
  logic [K-1:0][N-1:0] dec;
  logic [K-1:0][N-1:0] sym_in;
  logic                err_q, err_d;

  function automatic logic is_onehot(input logic [S-1:0] st);
    return (st != '0) && ((st & (st - S'(1))) == '0);
  endfunction

  // OR of set-bit indices; only meaningful for a one-hot input.
  function automatic logic [N-1:0] dec_onehot(input logic [S-1:0] st);
    logic [N-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < S; i++) begin
      if (st[i]) v |= N'(i);
    end
    return v;
  endfunction

  always_comb begin
    legal  = '0;
    dec    = '0;
    sym_in = '0;
    st_d   = '0;
    err_d  = err_q;

    for (int unsigned k = 0; k < K; k++) begin
      legal[k] = is_onehot(st_q[k]);
      // An illegal stage presents symbol 0 to its successor.
      dec[k]   = legal[k] ? dec_onehot(st_q[k]) : '0;
    end

    sym_in[0] = bus.data_in;
    for (int unsigned k = 1; k < K; k++) begin
      sym_in[k] = dec[k-1];
    end

    for (int unsigned k = 0; k < K; k++) begin
      // Recovery to S0 wins over the normal transition.
      st_d[k] = legal[k] ? (S'(1) << sym_in[k]) : S'(1);
    end

    err_d = err_q | ~(&legal);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      st_q  <= {K{S'(1)}};
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      err_q <= err_d;
    end
  end

  assign bus.data_out  = dec[K-1];
  assign bus.err_state = err_q;

endmodule

// File: tb/tb_fsm_chain.sv
// Bench for fsm_chain: a K=32/N=4 chain and a K=1/N=2 corner instance share clock
// and reset. Expected outputs come from a symbol-level delay model.
module tb_fsm_chain;

  localparam int unsigned N  = 4;
  localparam int unsigned K  = 32;
  localparam int unsigned S  = 1 << N;
  localparam int unsigned N2 = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fsm_chain_if #(.N(N))  bus  ();
  fsm_chain_if #(.N(N2)) bus2 ();

  fsm_chain #(.N(N), .K(K)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  fsm_chain #(.N(N2), .K(1)) dut2 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Symbol-level model: mdl[i] is the symbol held by stage i+1.
  int mdl [K];
  bit mdl_err;
  int mdl2;
  int kill_idx = -1;

  logic [K-1:0][S-1:0] st_v;

  task automatic clear_model();
    for (int k = 0; k < K; k++) mdl[k] = 0;
    mdl2     = 0;
    mdl_err  = 1'b0;
    kill_idx = -1;
  endtask

  // Called at a negedge; drives inputs, advances model on the posedge, returns at negedge.
  task automatic drive_cycle(input int d, input int d2);
    bus.data_in  = N'(d);
    bus2.data_in = N2'(d2);
    @(posedge clk);
    if (rst_n) begin
      for (int k = K - 1; k > 0; k--) mdl[k] = (kill_idx == k - 1) ? 0 : mdl[k-1];
      mdl[0] = d;
      if (kill_idx >= 0) begin
        mdl[kill_idx] = 0;
        mdl_err       = 1'b1;
      end
      kill_idx = -1;
      mdl2     = d2;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.data_in  = '0;
    bus2.data_in = '0;
    clear_model();
    for (int i = 0; i < 8; i++) begin
      bus.data_in  = N'($urandom_range(0, 15));
      bus2.data_in = N2'($urandom_range(0, 3));
      @(negedge clk);
      n_tests++;
      if (bus.data_out !== 4'd0 || bus.err_state !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: data_o=%0d err=%0b, required 0/0", bus.data_out,
                 bus.err_state);
      end
      n_tests++;
      if (bus2.data_out !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_hold_k1: data_o=%0d, required 0", bus2.data_out);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < K + 4; i++) begin
      drive_cycle(0, 0);
      n_tests++;
      if (bus.data_out !== 4'd0 || bus.err_state !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release: cycle %0d data_o=%0d err=%0b, required 0/0", i,
                 bus.data_out, bus.err_state);
      end
    end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 80; i++) begin
      drive_cycle(i % 15, i % 4);
      n_tests++;
      if (bus.data_out !== N'(mdl[K-1]) || bus.err_state !== mdl_err) begin
        n_fail++;
        $display("FAIL streaming: cycle %0d data_o=%0d err=%0b, required %0d/%0b", i,
                 bus.data_out, bus.err_state, mdl[K-1], mdl_err);
      end
    end
  endtask

  task automatic test_out_of_range();
    int pos;
    int seen;
    pos  = int'($urandom_range(5, 30));
    seen = 0;
    for (int i = 0; i < K + 40; i++) begin
      drive_cycle((i == pos) ? 15 : (i % 15), 0);
      if (bus.data_out === 4'd15) seen++;
      n_tests++;
      if (bus.data_out !== N'(mdl[K-1])) begin
        n_fail++;
        $display("FAIL out_of_range: cycle %0d data_o=%0d, required %0d", i, bus.data_out,
                 mdl[K-1]);
      end
    end
    n_tests++;
    if (seen != 1) begin
      n_fail++;
      $display("FAIL out_of_range_count: saw 15 on %0d cycles, required 1", seen);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 100; i++) begin
      drive_cycle(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      n_tests++;
      if (bus.data_out !== N'(mdl[K-1]) || bus.err_state !== mdl_err) begin
        n_fail++;
        $display("FAIL random: cycle %0d data_o=%0d err=%0b, required %0d/%0b", i,
                 bus.data_out, bus.err_state, mdl[K-1], mdl_err);
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 20; i++) drive_cycle(i % 15, 0);
    rst_n = 1'b0;
    #1;
    clear_model();
    n_tests++;
    if (bus.data_out !== 4'd0 || bus.err_state !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_immediate: data_o=%0d err=%0b, required 0/0", bus.data_out,
               bus.err_state);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < K + 20; i++) begin
      drive_cycle((i % 14) + 1, 0);
      n_tests++;
      if (bus.data_out !== N'(mdl[K-1])) begin
        n_fail++;
        $display("FAIL midreset_refill: cycle %0d data_o=%0d, required %0d", i, bus.data_out,
                 mdl[K-1]);
      end
    end
  endtask

  task automatic test_illegal_state();
    for (int i = 0; i < K; i++) drive_cycle(int'($urandom_range(1, 15)), 0);
    st_v    = dut.st_q;
    st_v[4] = S'(16'h0009);
    force dut.st_q = st_v;
    #1;
    release dut.st_q;
    n_tests++;
    if (bus.err_state !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_pre_edge: err=%0b, required 0", bus.err_state);
    end
    kill_idx = 4;
    for (int i = 0; i < 2 * K; i++) begin
      drive_cycle(int'($urandom_range(1, 15)), 0);
      n_tests++;
      if (bus.data_out !== N'(mdl[K-1]) || bus.err_state !== 1'b1) begin
        n_fail++;
        $display("FAIL illegal_state: cycle %0d data_o=%0d err=%0b, required %0d/1", i,
                 bus.data_out, bus.err_state, mdl[K-1]);
      end
    end
  endtask

  task automatic test_param_corner();
    for (int i = 0; i < 40; i++) begin
      drive_cycle(0, (i < 8) ? (i % 4) : int'($urandom_range(0, 3)));
      n_tests++;
      if (bus2.data_out !== N2'(mdl2) || bus2.err_state !== 1'b0) begin
        n_fail++;
        $display("FAIL k1_corner: cycle %0d data_o=%0d err=%0b, required %0d/0", i,
                 bus2.data_out, bus2.err_state, mdl2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_out_of_range();
    test_random();
    test_reset_midstream();
    test_illegal_state();
    test_param_corner();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fsm_chain.md
# fsm_chain

Delay line of K cascaded state-machine stages carrying an N-bit symbol from input to output. It serves as the fault-tolerance test payload between the pattern generator and the sequence checker. Each stage is a Moore FSM with 2^N one-hot-encoded states, and the stage's state is its held symbol. Illegal (non-one-hot) stage states are detected, recovered and flagged, so upset or TMR experiments can observe state corruption.

## Interface
- N, default 4: symbol width; each stage has 2^N states.
- K, default 32: number of stages (K ≥ 1).

- clk_i  in  1  sole clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- data_i  in  N  input symbol, sampled every clock.
- data_o  out  N  binary-decoded state of stage K.
- err_state_o  out  1  sticky flag; set when any stage held an illegal state.

## Operation
- Stage k holds a one-hot state register st[k] of 2^N bits, with states S0..S(2^N−1).
- Encoding: state Sv ⇔ st[k] has only bit v set.
- Stage 1 next state: S(data_i).
- Stage k>1 next state: S(dec(st[k−1])), where dec is the one-hot→binary decode.
- Transitions are unconditional every clock; there is no enable or stall.
- Legality check per stage: st[k] is legal iff exactly one bit is set.
- Illegal current state in stage k:
  - Stage k's next state is S0. This takes priority over the normal transition.
  - dec() of an illegal state yields 0, so stage k+1 receives symbol 0.
  - err_state_o is set at the same clock edge.
- err_state_o is sticky: it is cleared only by reset.
- Several stages illegal in the same cycle: each recovers independently, and one flag covers all.
- data_o = dec(st[K]), combinational from registers with no output register.
- All 2^N symbol values pass unchanged, including values outside the generator's normal counting range (e.g. 15 with N=4).
- The chain performs no arithmetic; symbol width is preserved exactly.
- Reset (rst_i = 0), asynchronous:
  - all st[k] = S0 (bit 0 set), so data_o = 0;
  - err_state_o = 0.
  - Outputs take these values immediately on assertion and hold them while reset is low.
- Release is synchronous-safe: the first capture happens on the first rising edge with rst_i = 1.
- Reset mid-operation discards all in-flight symbols. After release the chain refills, and data_o shows 0 until the first post-reset symbol arrives.

## Timing
- Latency is exactly K clocks. A data_i value sampled at edge e appears on data_o after edge e+K−1 and is valid for one cycle.
- Throughput is one symbol per clock.
- Illegal state present before edge e:
  - err_state_o = 1 after edge e.
  - The stage shows S0 after edge e.
- Delay through the remaining stages is unchanged by recovery.
- No combinational path from data_i to any output.

## Test plan
- Reset: hold rst_i = 0 with data_i toggling → data_o = 0 and err_state_o = 0 throughout. After release with data_i = 0, data_o stays 0.
- Streaming, N=4, K=32: release reset, then drive the counting pattern 0,1,…,14,0,1,… one per clock. Required response:
  - data_o equals the identical sequence delayed by exactly 32 clocks;
  - data_o = 0 before the first symbol arrives;
  - err_state_o remains 0.
- Out-of-range symbol: during counting, replace one value with 15 for a single cycle → data_o = 15 for exactly one cycle, 32 clocks later; neighbouring values are unchanged.
- Reset mid-stream: after 20 clocks of counting, pulse rst_i low for one cycle. Required response:
  - data_o = 0 immediately;
  - the first post-release symbol appears after 32 clocks;
  - no stale pre-reset symbols ever appear.
- Illegal state: force st[5] to bits 0 and 3 set, for one cycle. Required response:
  - err_state_o = 1 at the next edge and stays 1 until reset;
  - the corresponding symbol emerges as 0 at data_o;
  - later symbols pass correctly.
- Parameter corner: K=1, N=2 → data_o follows data_i with a 1-clock delay over all values 0–3.
